switch_cmd_encoder: RTL and testbench
=====================================

// Module: switch_cmd_encoder
// PURPOSE
//  Parametrised successor to the single-channel switch-to-command encoder.
//  - Synchronises and debounces a bank of select switches, then encodes the settled value as an 8-bit command byte {payload, channel}.
//  - Presents the byte on a valid/ready handshake to the UART transmit path.
//  - Optional periodic resend (heartbeat) keeps the remote side refreshed.
//  - Sits between board switches and uart_tx; one instance per switch bank.
// PARAMETERS
//  SEL_W          5        switch bank width, 1..6 (payload field is 6 bits)
//  DEBOUNCE_CNT   5000000  consecutive stable cycles before a value is accepted (>=2)
//  SEL_MAX        20       largest legal select value; larger values encode IGNORE
//  CHANNEL_ID     2'b11    channel tag placed in data[1:0]
//  RESEND_CYCLES  0        0 = send on change only; N>0 = resend last byte every N idle cycles
// PORTS
//  clk              in   1      system clock
//  rst              in   1      synchronous reset, active-high
//  select_switches  in   SEL_W  raw asynchronous switch inputs
//  out_ready        in   1      downstream (uart_tx) can accept a byte this cycle
//  out_valid        out  1      data holds a byte to transmit
//  data             out  8      {payload[5:0], channel[1:0]}
//  busy_settling    out  1      input changed, debounce counter running
// BEHAVIOUR
//  Reset (rst=1 at posedge): out_valid=0, data=8'h00, busy_settling=0.
//   - Sync flops, prev, counter and resend timer cleared; last_committed set to an invalid marker.
//   - The first settled value after reset is always sent.
//  Sync: 2-flop synchroniser on select_switches -> sw_s.
//  Debounce:
//   - Register prev.
//   - sw_s != prev: prev<=sw_s, cnt<=0, busy_settling<=1.
//   - Otherwise cnt increments, saturating at DEBOUNCE_CNT.
//   - Commit happens on the edge where cnt goes DEBOUNCE_CNT-1 -> DEBOUNCE_CNT; busy_settling<=0 on that edge.
//  Latency: a switch change first sampled at edge k gives out_valid=1 after edge k+DEBOUNCE_CNT+2.
//  Commit suppressed when settled value == last_committed (bounce back to the old value sends nothing).
//  Encoding:
//   - sel > SEL_MAX -> data = 8'b000000_11 (IGNORE).
//   - else data = {zero-extend(sel) to 6 bits, CHANNEL_ID}.
//   - Comparison is unsigned at SEL_W bits.
//  Handshake:
//   - Transfer when out_valid && out_ready at a posedge; out_valid<=0 next cycle unless a new commit occurs on that same edge.
//   - While out_valid=1, data is stable until transfer, except overwrite:
//     a new commit while out_valid && !out_ready replaces data (latest wins); out_valid stays 1 and no byte is queued.
//   - Commit and transfer on the same edge: new byte loaded, out_valid stays 1.
//  Resend (RESEND_CYCLES>0):
//   - Timer counts cycles with out_valid=0 and busy_settling=0.
//   - At RESEND_CYCLES it reloads the last committed byte and sets out_valid=1, then restarts.
//   - Any commit, input change or rst clears the timer.
//   - Never fires before the first commit.
//  Reset mid-settle or mid-handshake drops the pending byte; no partial transfer.
//  States (out FSM): IDLE (valid=0) -> PEND on commit or resend.
//   - PEND -> IDLE on transfer with no concurrent commit.
//   - PEND -> PEND on overwrite.
// STRUCTURE
//  - Shared header cmd_defs.vh: CMD_IGNORE=8'b000000_11, channel tag constants (CH_TARGET=2'b11 etc.), PAYLOAD_W=6.
//  - Sub-module switch_debouncer #(W, CNT): synchroniser + stability counter; outputs settled value, commit pulse, settling flag.
//  - Top: encoder, output register/FSM, resend timer.
// TESTING (bench: DEBOUNCE_CNT=4, SEL_MAX=20, CHANNEL_ID=2'b11)
//  1. After rst, switches=5'd3, out_ready=1 -> out_valid pulses 1 cycle with data=8'h0F, 6 cycles after first sample edge.
//  2. switches=5'd25 -> data=8'h03 (IGNORE).
//  3. Glitch 3->7->3 with each level held 2 cycles -> no out_valid.
//  4. out_ready=0; commit 9 (8'h27), then 12 (8'h33) -> out_valid held, data=8'h33.
//     Raise out_ready -> exactly one transfer of 8'h33.
//  5. RESEND_CYCLES=10, switches fixed at 4, out_ready=1 -> 8'h13 resent every 10+1 cycles.
//     Toggling rst mid-cycle stops resend until the next commit.
//  6. Assert rst while busy_settling=1 -> outputs 0 next cycle; the settled value after release is sent once.

Source files
------------

// File: rtl/switch_cmd_encoder_pkg.sv
// Shared constants, output FSM states and the command-byte encoder used by
// switch_cmd_encoder.
package switch_cmd_encoder_pkg;

  localparam int unsigned PayloadW = 6;

  localparam logic [7:0] CmdIgnore = 8'b000000_11;

  localparam logic [1:0] ChControl = 2'b00;
  localparam logic [1:0] ChTarget  = 2'b11;

  typedef enum logic [0:0] {
    StIdle,
    StPend
  } out_state_e;

  // Out-of-range selects collapse to the fixed IGNORE byte, whatever the channel.
  function automatic logic [7:0] encode_cmd(input logic [PayloadW-1:0] sel,
                                            input logic [PayloadW-1:0] sel_max,
                                            input logic [1:0]          channel);
    return (sel > sel_max) ? CmdIgnore : {sel, channel};
  endfunction

endpackage

// File: rtl/switch_cmd_encoder_debouncer.sv
// Two-flop synchroniser plus stability counter for a switch bank. Pulses
// stable_pulse once when the synchronised value has held for CNT cycles.
module switch_cmd_encoder_debouncer #(
  parameter int unsigned W   = 5,
  parameter int unsigned CNT = 5000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw_raw,
  output logic [W-1:0] settled,
  output logic         stable_pulse,
  output logic         changed,
  output logic         settling
);

  localparam int unsigned       CntW    = $clog2(CNT + 1);
  localparam logic [CntW-1:0]   CntMax  = CntW'(CNT);
  localparam logic [CntW-1:0]   CntLast = CntW'(CNT - 1);

  logic [W-1:0]    sync1_q, sync2_q, prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            settling_q, settling_d;

  assign changed      = (sync2_q != prev_q);
  assign stable_pulse = !changed && (cnt_q == CntLast);
  assign settled      = prev_q;
  assign settling     = settling_q;

  always_comb begin
    cnt_d      = cnt_q;
    settling_d = settling_q;
    if (changed) begin
      cnt_d      = '0;
      settling_d = 1'b1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
      if (stable_pulse) settling_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      settling_q <= 1'b0;
    end else begin
      sync1_q    <= sw_raw;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      cnt_q      <= cnt_d;
      settling_q <= settling_d;
    end
  end

endmodule

// File: rtl/switch_cmd_encoder.sv
// Debounced switch bank to {payload, channel} command byte, presented on a
// valid/ready handshake with optional periodic resend of the last byte.
module switch_cmd_encoder
  import switch_cmd_encoder_pkg::*;
#(
  parameter int unsigned SEL_W         = 5,
  parameter int unsigned DEBOUNCE_CNT  = 5000000,
  parameter int unsigned SEL_MAX       = 20,
  parameter logic [1:0]  CHANNEL_ID    = ChTarget,
  parameter int unsigned RESEND_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] select_switches,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       data,
  output logic             busy_settling
);

  // SEL_MAX beyond the bank's range means no value is ever out of range.
  localparam int unsigned         SelLimit  = (1 << SEL_W) - 1;
  localparam int unsigned         SelMaxSat = (SEL_MAX > SelLimit) ? SelLimit : SEL_MAX;
  localparam logic [PayloadW-1:0] SelMaxP   = PayloadW'(SelMaxSat);
  localparam bit                  ResendEn  = (RESEND_CYCLES > 0);
  localparam int unsigned         TimerW    = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
  localparam logic [TimerW-1:0]   TimerLast = TimerW'(ResendEn ? RESEND_CYCLES - 1 : 0);

  logic [SEL_W-1:0]  settled, last_sel_q;
  logic              stable_pulse, changed, settling;
  logic              last_ok_q;
  logic              commit, fire;
  logic [7:0]        new_byte, resend_byte;
  out_state_e        state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [TimerW-1:0] timer_q, timer_d;

  switch_cmd_encoder_debouncer #(
    .W   (SEL_W),
    .CNT (DEBOUNCE_CNT)
  ) u_debouncer (
    .clk          (clk),
    .rst          (rst),
    .sw_raw       (select_switches),
    .settled      (settled),
    .stable_pulse (stable_pulse),
    .changed      (changed),
    .settling     (settling)
  );

  // A settle back onto the value already sent is not a new command.
  assign commit = stable_pulse && (!last_ok_q || (settled != last_sel_q));
  assign fire   = ResendEn && last_ok_q && (state_q == StIdle) && !settling &&
                  (timer_q == TimerLast);

  assign new_byte    = encode_cmd(PayloadW'(settled), SelMaxP, CHANNEL_ID);
  assign resend_byte = encode_cmd(PayloadW'(last_sel_q), SelMaxP, CHANNEL_ID);

  always_comb begin
    timer_d = timer_q;
    if (commit || changed || fire) begin
      timer_d = '0;
    end else if (ResendEn && last_ok_q && (state_q == StIdle) && !settling) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          data_d  = new_byte;
          state_d = StPend;
        end else if (fire) begin
          data_d  = resend_byte;
          state_d = StPend;
        end
      end
      StPend: begin
        if (commit) begin
          data_d = new_byte;
        end else if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      data_q     <= '0;
      timer_q    <= '0;
      last_sel_q <= '0;
      last_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      if (commit) begin
        last_sel_q <= settled;
        last_ok_q  <= 1'b1;
      end
    end
  end

  assign out_valid     = (state_q == StPend);
  assign data          = data_q;
  assign busy_settling = settling;

endmodule

// File: tb/tb_switch_cmd_encoder.sv
// Directed scenarios followed by random switch/ready/reset traffic, all checked
// every cycle against a timestamp-based reference model of the encoder.
module tb_switch_cmd_encoder;

  localparam int unsigned SelW   = 5;
  localparam int unsigned Deb    = 4;
  localparam int unsigned SelMax = 20;
  localparam int unsigned Resend = 10;
  localparam logic [1:0]  Ch     = 2'b11;

  logic            clk = 1'b0;
  logic            rst;
  logic [SelW-1:0] select_switches;
  logic            out_ready;
  logic            out_valid;
  logic [7:0]      data;
  logic            busy_settling;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_cmd_encoder #(
    .SEL_W         (SelW),
    .DEBOUNCE_CNT  (Deb),
    .SEL_MAX       (SelMax),
    .CHANNEL_ID    (Ch),
    .RESEND_CYCLES (Resend)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .select_switches (select_switches),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .data            (data),
    .busy_settling   (busy_settling)
  );

  // Reference model: synchroniser as a 2-deep delay line, settling judged by
  // the edge number of the last disturbance (change or reset).
  int unsigned edge_n = 0;
  int unsigned last_dist, quiet, have_sel, prev_sw;
  int unsigned pipe[$];
  bit          dist_change, m_busy, m_valid, have;
  logic [7:0]  m_data;
  int          xfer_cnt = 0;

  function automatic logic [7:0] exp_cmd(input int unsigned v);
    return (v > SelMax) ? 8'h03 : 8'(v * 4 + int'(Ch));
  endfunction

  task automatic model_step();
    int unsigned sw;
    bit change, commit, fire, busy_pre, valid_pre;
    edge_n++;
    if (rst) begin
      pipe.delete();
      pipe.push_back(0);
      pipe.push_back(0);
      prev_sw = 0; last_dist = edge_n; dist_change = 0;
      m_busy = 0; m_valid = 0; m_data = 8'h00; have = 0; quiet = 0;
      return;
    end
    busy_pre  = m_busy;
    valid_pre = m_valid;
    sw = pipe.pop_front();
    pipe.push_back(int'(select_switches));
    change  = (sw != prev_sw);
    prev_sw = sw;
    if (change) begin
      last_dist   = edge_n;
      dist_change = 1;
    end
    commit = ((edge_n - last_dist) == Deb) && (!have || sw != have_sel);
    fire   = !commit && have && !valid_pre && !busy_pre && (quiet == Resend - 1);
    if (commit || change || fire) quiet = 0;
    else if (have && !valid_pre && !busy_pre) quiet++;
    m_busy = dist_change && ((edge_n - last_dist) < Deb);
    if (commit) begin
      m_valid = 1; m_data = exp_cmd(sw); have = 1; have_sel = sw;
    end else if (fire) begin
      m_valid = 1; m_data = exp_cmd(have_sel);
    end else if (valid_pre && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", tag, edge_n, got, exp);
    end
  endtask

  // One clock: advance model at the edge, compare outputs on the falling edge.
  task automatic tick();
    if (out_valid === 1'b1 && out_ready === 1'b1) xfer_cnt++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(busy_settling), 32'(m_busy));
    if (m_valid) check("data", 32'(data), 32'(m_data));
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, cnt, last, pulses;
    rst = 1'b1; select_switches = 5'd3; out_ready = 1'b1;

    // 1: reset state, then first value after reset sent 6 edges after sampling
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_busy", 32'(busy_settling), 32'd0);
    rst = 1'b0;
    wait_valid(20, n);
    check("latency", 32'(n), 32'd7);
    check("first_data", 32'(data), 32'h0F);
    tick();
    check("pulse_1cyc", 32'(out_valid), 32'd0);

    // 2: out-of-range select
    select_switches = 5'd25;
    wait_valid(20, n);
    check("ignore", 32'(data), 32'h03);
    tick();

    // 3: glitch away from and back to the committed value
    select_switches = 5'd3;
    wait_valid(20, n);
    check("recommit3", 32'(data), 32'h0F);
    tick();
    cnt = 0;
    select_switches = 5'd7;
    for (int i = 0; i < 2; i++) begin tick(); cnt += int'(out_valid); end
    select_switches = 5'd3;
    for (int i = 0; i < 10; i++) begin tick(); cnt += int'(out_valid); end
    check("glitch_quiet", 32'(cnt), 32'd0);

    // 4: overwrite while stalled, then a single transfer
    out_ready = 1'b0;
    select_switches = 5'd9;
    wait_valid(20, n);
    check("stall_9", 32'(data), 32'h27);
    select_switches = 5'd12;
    for (int i = 0; i < 10; i++) tick();
    check("held_valid", 32'(out_valid), 32'd1);
    check("overwrite", 32'(data), 32'h33);
    out_ready = 1'b1;
    xfer_cnt = 0;
    for (int i = 0; i < 5; i++) tick();
    check("one_xfer", 32'(xfer_cnt), 32'd1);

    // 5: periodic resend, then reset suppresses it until the next commit
    select_switches = 5'd4;
    wait_valid(20, n);
    check("commit4", 32'(data), 32'h13);
    last = int'(edge_n);
    pulses = 1;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        check("resend_gap", 32'(int'(edge_n) - last), 32'd11);
        check("resend_data", 32'(data), 32'h13);
        last = int'(edge_n);
        pulses++;
      end
    end
    check("resend_count", 32'(pulses), 32'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(); cnt += int'(out_valid); end
    check("post_rst_quiet", 32'(cnt), 32'd0);
    wait_valid(20, n);
    check("post_rst_send", 32'(data), 32'h13);

    // 6: reset while settling drops the pending value
    select_switches = 5'd17;
    tick(); tick(); tick();
    check("settling", 32'(busy_settling), 32'd1);
    rst = 1'b1; tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy_settling), 32'd0);
    check("mid_rst_data", 32'(data), 32'h00);
    rst = 1'b0;
    wait_valid(20, n);
    check("mid_rst_latency", 32'(n), 32'd7);
    check("mid_rst_send", 32'(data), 32'h47);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); cnt += int'(out_valid); end
    check("sent_once", 32'(cnt), 32'd0);

    // Random traffic
    for (int s = 0; s < 70; s++) begin
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      select_switches = 5'($urandom_range(0, 31));
      for (int h = int'($urandom_range(1, 12)); h > 0; h--) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
